// File: rtl/binary_sub_serial.sv
// binary_sub_serial: bit-serial two's-complement subtractor, D = A - B.
// Computes A + ~B + 1 LSB-first, one bit per enabled clock. The inverted
// subtrahend is captured at start and the carry is seeded with 1, so the
// serial adder core is identical to the one in the registered adder.
// start/busy/done handshake; D, borrow and ovf hold until the next capture.
module binary_sub_serial #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;

  // Datapath state. nb_q holds ~B so SHIFT is a plain full-adder step.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] nb_q;
  logic [WIDTH-1:0] d_q;
  logic             carry_q;
  logic             borrow_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] idx;
  logic             a_bit, nb_bit;
  logic             sum_bit, carry_nxt;
  logic             last_bit;
  logic             accept;

  // A start is only sampled outside SHIFT; in SHIFT it is dropped, not queued.
  assign accept   = start && (state != S_SHIFT);
  assign last_bit = (cnt_q == LAST);
  assign idx      = cnt_q[IDX_W-1:0];
  assign a_bit    = a_q[idx];
  assign nb_bit   = nb_q[idx];

  // One full-adder slice of A + ~B + carry for the current bit position.
  always_comb begin
    sum_bit   = a_bit ^ nb_bit ^ carry_q;
    carry_nxt = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
  end

  // State register: reset wins, en=0 stalls.
  always_ff @(posedge clk) begin
    if (rst)     state <= S_IDLE;
    else if (en) state <= state_nxt;
  end

  // Next-state: start in DONE restarts immediately rather than passing IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    busy = (state == S_SHIFT);
    done = (state == S_DONE);
  end

  // Datapath: capture on accepted start, one result bit per SHIFT cycle.
  // D is not cleared on capture; it only becomes meaningful once done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      nb_q     <= '0;
      d_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (en) begin
      if (accept) begin
        a_q     <= A;
        nb_q    <= ~B;
        carry_q <= 1'b1;
        cnt_q   <= '0;
      end else if (state == S_SHIFT) begin
        d_q[idx] <= sum_bit;
        carry_q  <= carry_nxt;
        cnt_q    <= cnt_q + 1'b1;
        if (last_bit) begin
          // Final carry set means no borrow was needed.
          borrow_q <= ~carry_nxt;
          // Operand signs differ (A MSB equals ~B MSB) and result sign
          // disagrees with the minuend.
          ovf_q    <= (a_bit == nb_bit) && (sum_bit != a_bit);
        end
      end
    end
  end

  assign D      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_binary_sub_serial.sv
// tb_binary_sub_serial: scoreboard bench for the serial subtractor (WIDTH=5).
// Expected results are queued when a start is driven and compared when done rises.
module tb_binary_sub_serial;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, en, start;
  logic [W-1:0] A, B;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] D;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         brw;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;
  logic prev_done = 1'b0;

  binary_sub_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .D(D), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic difference, unsigned compare, sign rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.d   = a - b;
    e.brw = (a < b);
    e.ov  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    return e;
  endfunction

  // Scoreboard consumer: one pop per rising done.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        int   f0;
        e  = q.pop_front();
        f0 = n_fail;
        chk("D", D, e.d);
        chk("borrow", borrow, e.brw);
        chk("ovf", ovf, e.ov);
        $display("op A=%0d B=%0d D=%b %s", $signed(e.a), $signed(e.b), D,
                 (n_fail == f0) ? "PASS" : "ERROR");
      end
    end
    prev_done = done;
  end

  // Drive a one-cycle start just after the next rising edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) chk("timeout_done", 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_D", D, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_ovf", ovf, 0);

    // T1: latency and one-cycle done.
    drive_start(5'd7, 5'd3);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1_busy%0d", k), busy, (k < 5));
      chk($sformatf("t1_done%0d", k), done, (k == 5));
    end
    @(negedge clk);
    chk("t1_done_fall", done, 0);

    // T2: negative result and signed overflow.
    drive_start(5'd3, 5'd7);
    wait_done();
    drive_start(5'b10000, 5'd1);
    wait_done();

    // T3: start held through SHIFT, operands changed mid-op, restart from DONE.
    @(posedge clk); #1;
    A = 5'd15; B = 5'b10000; start = 1'b1;
    q.push_back(model(5'd15, 5'b10000));
    @(posedge clk); #1;
    A = 5'd9; B = 5'd2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t3_busy%0d", k), busy, 1);
    end
    wait_done();
    q.push_back(model(5'd9, 5'd2));
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t3_restart_busy", busy, 1);
    chk("t3_restart_done", done, 0);
    wait_done();

    // T4: stall 3 cycles mid-SHIFT, then stall in DONE.
    drive_start(5'd12, 5'd21);
    repeat (2) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_stall_busy%0d", k), busy, 1);
      chk($sformatf("t4_stall_done%0d", k), done, 0);
    end
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t4_done%0d", k), done, (k == 2));
    end
    en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t4_done_hold", done, 1);
    end
    en = 1'b1;
    @(negedge clk);
    chk("t4_done_fall", done, 0);

    // T5: reset at bit 2 aborts with no done.
    drive_start(5'd30, 5'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q.pop_back());
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_D", D, 0);
    chk("t5_borrow", borrow, 0);
    chk("t5_ovf", ovf, 0);
    begin
      int nd;
      nd = n_done;
      repeat (10) @(negedge clk);
      chk("t5_no_done", n_done, nd);
    end

    // T6: exhaustive signed operand sweep.
    for (int i = -16; i < 16; i++) begin
      for (int j = -16; j < 16; j++) begin
        drive_start(W'(i), W'(j));
        wait_done();
      end
    end
    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
